// File: rtl/mac_result_requant.sv
// Rebuilds 18-bit MAC results from tagged half-words, applies bias, shift and
// activation clamp, and queues the 8-bit results behind a valid/ready port.
module mac_result_requant #(
    parameter int DEPTH  = 4,
    parameter int BIAS_W = 12,
    parameter bit RELU   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [9:0]        in_word,
    input  logic              cfg_we,
    input  logic              cfg_addr,
    input  logic [BIAS_W-1:0] cfg_wdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_data,
    output logic              sync_err,
    output logic              ovf_err,
    input  logic              err_clr
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic {WAIT_HI, WAIT_LO} pair_state_t;

    logic signed [BIAS_W-1:0] bias;
    logic [4:0]               shift;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            bias  <= '0;
            shift <= '0;
        end else if (cfg_we) begin
            if (cfg_addr) shift <= cfg_wdata[4:0];
            else          bias  <= $signed(cfg_wdata);
        end
    end

    pair_state_t state, state_next;
    logic [8:0]  hi_q;
    logic        is_lo, launch, hi_load, pair_err;

    assign is_lo = in_word[9];

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_next = state;
        launch     = 1'b0;
        hi_load    = 1'b0;
        pair_err   = 1'b0;
        if (in_valid) begin
            unique case (state)
                WAIT_HI: begin
                    if (is_lo) begin
                        pair_err = 1'b1;
                    end else begin
                        hi_load    = 1'b1;
                        state_next = WAIT_LO;
                    end
                end
                WAIT_LO: begin
                    if (is_lo) begin
                        launch     = 1'b1;
                        state_next = WAIT_HI;
                    end else begin
                        hi_load  = 1'b1;
                        pair_err = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= WAIT_HI;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (hi_load) hi_q <= in_word[8:0];
    end

    // Stage 1: unsigned result plus sign-extended bias; 20 bits cannot overflow.
    logic signed [19:0] sum_next, s1_sum;
    logic               s1_valid;

    assign sum_next = $signed({2'b00, hi_q, in_word[8:0]})
                    + $signed({{(20-BIAS_W){bias[BIAS_W-1]}}, bias});

    always_ff @(posedge clk) begin
        if (rst) s1_valid <= 1'b0;
        else     s1_valid <= launch;
        if (launch) s1_sum <= sum_next;
    end

    // Stage 2: arithmetic shift, clamp, register.
    logic [4:0]         sh_amt;
    logic signed [19:0] shifted;
    logic [7:0]         clamped;
    logic [7:0]         s2_data;
    logic               s2_valid;

    assign sh_amt  = (shift > 5'd19) ? 5'd19 : shift;
    assign shifted = s1_sum >>> sh_amt;

    always_comb begin
        clamped = shifted[7:0];
        if (RELU) begin
            if (shifted < 20'sd0)        clamped = 8'h00;
            else if (shifted > 20'sd255) clamped = 8'hFF;
        end else begin
            if (shifted < -20'sd128)     clamped = 8'h80;
            else if (shifted > 20'sd127) clamped = 8'h7F;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) s2_valid <= 1'b0;
        else     s2_valid <= s1_valid;
        if (s1_valid) s2_data <= clamped;
    end

    // Result FIFO; the registered head shows an entry one edge after its push.
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_next;
    logic [AW:0]   count, count_after_pop;
    logic          pop, full, push_ok, drop;

    assign pop             = out_valid && out_ready;
    assign full            = (count == (AW+1)'(DEPTH));
    assign push_ok         = s2_valid && (!full || pop);
    assign drop            = s2_valid && full && !pop;
    assign rd_ptr_next     = rd_ptr + AW'(pop);
    assign count_after_pop = count - (AW+1)'(pop);

    // NOTE: storage carries no reset; the pointers and count alone define
    // which entries are live, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= s2_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_data  <= 8'h00;
        end else begin
            rd_ptr    <= rd_ptr_next;
            wr_ptr    <= wr_ptr + AW'(push_ok);
            count     <= count_after_pop + (AW+1)'(push_ok);
            out_valid <= (count_after_pop != '0);
            if (count_after_pop != '0) out_data <= mem[rd_ptr_next];
        end
    end

    // Sticky flags: a set event outranks a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_err <= 1'b0;
            ovf_err  <= 1'b0;
        end else begin
            if (pair_err)     sync_err <= 1'b1;
            else if (err_clr) sync_err <= 1'b0;
            if (drop)         ovf_err  <= 1'b1;
            else if (err_clr) ovf_err  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mac_result_requant.sv
// Drives a ReLU and a saturating instance with shared stimulus and compares both
// against a cycle-stamped arithmetic model of the result stream.
module tb_mac_result_requant;

    localparam int DEPTH = 4;

    logic        clk, rst, in_valid, cfg_we, cfg_addr, out_ready, err_clr;
    logic [9:0]  in_word;
    logic [11:0] cfg_wdata;
    logic        r_valid, r_sync, r_ovf, s_valid, s_sync, s_ovf;
    logic [7:0]  r_data, s_data;

    mac_result_requant #(.DEPTH(DEPTH), .BIAS_W(12), .RELU(1'b1)) u_relu (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_word(in_word),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .out_valid(r_valid), .out_ready(out_ready), .out_data(r_data),
        .sync_err(r_sync), .ovf_err(r_ovf), .err_clr(err_clr));

    mac_result_requant #(.DEPTH(DEPTH), .BIAS_W(12), .RELU(1'b0)) u_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_word(in_word),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .out_valid(s_valid), .out_ready(out_ready), .out_data(s_data),
        .sync_err(s_sync), .ovf_err(s_ovf), .err_clr(err_clr));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: results in flight carry their launch cycle.
    typedef struct { int sum; int launch; int sh; } pend_t;
    typedef struct { int r; int s; } res_t;

    pend_t pend[$];
    res_t  mq[$];
    int    m_bias, m_shift, m_hi, cyc;
    bit    m_have_hi, m_valid, m_sync, m_ovf, rst_seen;
    int    n_cmp, n_bad;

    function automatic int relu_clamp(int v);
        if (v < 0)   return 0;
        if (v > 255) return 255;
        return v;
    endfunction

    function automatic int sat_clamp(int v);
        if (v < -128) return 'h80;
        if (v > 127)  return 'h7F;
        return v & 255;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_edge();
        bit    sset, oset, vis;
        pend_t p;
        int    v;
        if (rst) begin
            pend.delete(); mq.delete();
            m_bias = 0; m_shift = 0; m_have_hi = 0;
            m_valid = 0; m_sync = 0; m_ovf = 0; rst_seen = 1;
            cyc++;
            return;
        end
        rst_seen = 0; sset = 0; oset = 0;
        if (m_valid && out_ready) void'(mq.pop_front());
        vis = (mq.size() != 0);
        if (pend.size() > 0 && pend[0].launch == cyc - 2) begin
            p = pend.pop_front();
            v = p.sum >>> p.sh;
            if (mq.size() < DEPTH) mq.push_back('{r: relu_clamp(v), s: sat_clamp(v)});
            else                   oset = 1;
        end
        foreach (pend[i])
            if (pend[i].launch == cyc - 1) pend[i].sh = (m_shift > 19) ? 19 : m_shift;
        if (in_valid) begin
            if (!in_word[9]) begin
                if (m_have_hi) sset = 1;
                m_hi = int'(in_word[8:0]);
                m_have_hi = 1;
            end else if (!m_have_hi) begin
                sset = 1;
            end else begin
                pend.push_back('{sum: m_hi * 512 + int'(in_word[8:0]) + m_bias, launch: cyc, sh: 0});
                m_have_hi = 0;
            end
        end
        if (cfg_we) begin
            if (cfg_addr) m_shift = int'(cfg_wdata[4:0]);
            else          m_bias  = int'($signed(cfg_wdata));
        end
        if (sset)         m_sync = 1;
        else if (err_clr) m_sync = 0;
        if (oset)         m_ovf = 1;
        else if (err_clr) m_ovf = 0;
        m_valid = vis;
        cyc++;
    endtask

    task automatic check_outputs();
        check("r_valid", {31'b0, r_valid}, {31'b0, m_valid});
        check("s_valid", {31'b0, s_valid}, {31'b0, m_valid});
        if (m_valid) begin
            check("r_data", {24'b0, r_data}, mq[0].r);
            check("s_data", {24'b0, s_data}, mq[0].s);
        end
        if (rst_seen) begin
            check("r_data_rst", {24'b0, r_data}, 0);
            check("s_data_rst", {24'b0, s_data}, 0);
        end
        check("r_sync", {31'b0, r_sync}, {31'b0, m_sync});
        check("s_sync", {31'b0, s_sync}, {31'b0, m_sync});
        check("r_ovf", {31'b0, r_ovf}, {31'b0, m_ovf});
        check("s_ovf", {31'b0, s_ovf}, {31'b0, m_ovf});
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        in_valid = 0; cfg_we = 0; err_clr = 0;
        repeat (n) tick();
    endtask

    task automatic cfg(input bit addr, input int val);
        cfg_we = 1; cfg_addr = addr; cfg_wdata = val[11:0];
        tick();
        cfg_we = 0;
    endtask

    task automatic word(input bit tag, input int payload);
        in_valid = 1; in_word = {tag, payload[8:0]};
        tick();
        in_valid = 0;
    endtask

    task automatic send(input int result);
        word(1'b0, result >> 9);
        word(1'b1, result & 511);
    endtask

    task automatic expect3(input int er, input int es);
        tick(); tick();
        check("lat_early", {31'b0, r_valid}, 0);
        tick();
        check("lat_valid", {31'b0, r_valid}, 1);
        check("relu_val", {24'b0, r_data}, er);
        check("sat_val", {24'b0, s_data}, es);
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; cyc = 0;
        rst = 1; in_valid = 0; in_word = '0; cfg_we = 0; cfg_addr = 0;
        cfg_wdata = '0; out_ready = 1; err_clr = 0;
        tick(); tick();
        check("rst_valid", {31'b0, r_valid}, 0);
        rst = 0;

        // Bias, shift and both clamps at their boundaries.
        cfg(0, 20); cfg(1, 0);
        send('h0F0);            expect3('hFF, 'h7F);
        cfg(0, -8); cfg(1, 2);
        send(1000);             expect3('hF8, 'h7F);
        cfg(0, -300);
        send(100);              expect3('h00, 'hCE);
        cfg(0, 0); cfg(1, 10);
        send('h3FFFF);          expect3('hFF, 'h7F);
        cfg(0, -2048); cfg(1, 4);
        send(0);                expect3('h00, 'h80);
        cfg(0, 0); cfg(1, 0);

        // Pairing errors and sticky clear.
        word(1, 5);
        check("lo_in_wait_hi", {31'b0, r_sync}, 1);
        idle(4);
        check("lo_discarded", {31'b0, r_valid}, 0);
        word(0, 5); word(0, 0); word(1, 16);
        expect3(16, 16);
        err_clr = 1; tick(); err_clr = 0;
        check("sync_cleared", {31'b0, r_sync}, 0);
        idle(2);

        // Overflow with a stalled consumer, then drain and wrap.
        out_ready = 0;
        for (int i = 1; i <= 5; i++) send(i);
        idle(3);
        check("ovf_set", {31'b0, r_ovf}, 1);
        check("ovf_head", {24'b0, r_data}, 1);
        out_ready = 1;
        idle(6);
        check("drained", {31'b0, r_valid}, 0);
        err_clr = 1; tick(); err_clr = 0;
        for (int i = 1; i <= 9; i++) send(i);
        idle(4);
        check("no_ovf_wrap", {31'b0, r_ovf}, 0);

        // Reset mid-operation.
        out_ready = 0;
        send(7); send(8);
        idle(3);
        word(0, 3);
        rst = 1; tick(); rst = 0;
        check("rst_mid_valid", {31'b0, r_valid}, 0);
        word(1, 9);
        check("rst_lo_sync", {31'b0, r_sync}, 1);
        idle(4);
        check("rst_no_out", {31'b0, r_valid}, 0);
        out_ready = 1;
        err_clr = 1; tick(); err_clr = 0;

        // Randomized traffic with random backpressure, config and clears.
        for (int c = 0; c < 2000; c++) begin
            int roll;
            roll      = int'($urandom_range(0, 99));
            in_valid  = (roll < 75);
            if (m_have_hi) in_word[9] = ($urandom_range(0, 19) != 0);
            else           in_word[9] = ($urandom_range(0, 19) == 0);
            in_word[8:0] = 9'($urandom);
            out_ready = ($urandom_range(0, 9) < 6);
            err_clr   = ($urandom_range(0, 29) == 0);
            cfg_we    = ($urandom_range(0, 49) == 0);
            cfg_addr  = 1'($urandom);
            cfg_wdata = 12'($urandom);
            rst       = ($urandom_range(0, 399) == 0);
            tick();
        end
        rst = 0;
        idle(8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mac_result_requant.md
Name: mac_result_requant

Overview:
- Downstream stage of the 4-tap 8-bit dot-product MAC.
- Consumes the MAC's 10-bit tagged half-words and rebuilds each 18-bit unsigned dot-product result.
- Applies a programmable signed bias, an arithmetic right shift and an activation clamp, then requantizes to 8 bits.
- Results are buffered in a small FIFO behind a valid/ready output, for the next layer's byte-serial loader.

Parameters:
- DEPTH, 4, result FIFO entries (power of two, >=2).
- BIAS_W, 12, width of the signed bias register.
- RELU, 1, 1 = unsigned ReLU clamp to 0..255; 0 = signed saturation to -128..127 (two's complement).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  in_word valid this cycle
- in_word  in  10  MAC half-word: bit9 = tag, bits8:0 = payload
- cfg_we  in  1  config write strobe
- cfg_addr  in  1  0 = bias, 1 = shift
- cfg_wdata  in  BIAS_W  config write data (shift uses bits 4:0)
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts head
- out_data  out  8  requantized result
- sync_err  out  1  sticky pairing-error flag
- ovf_err  out  1  sticky FIFO-overflow flag
- err_clr  in  1  clears both sticky flags

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: out_valid = 0, out_data = 0, sync_err = 0, ovf_err = 0, bias = 0, shift = 0, FIFO empty, pairing FSM in WAIT_HI, pipeline valids cleared.
- Reset mid-operation discards any half-assembled result, in-flight pipeline data and FIFO contents.
- Half-word encoding:
  - tag = 0 → high half (result[17:9]).
  - tag = 1 → low half (result[8:0]).
- Pairing FSM, states WAIT_HI and WAIT_LO:
  - WAIT_HI + hi word: store payload, go to WAIT_LO.
  - WAIT_HI + lo word: discard it, set sync_err, stay in WAIT_HI.
  - WAIT_LO + lo word: form result = {hi, payload}, launch into the pipeline, go to WAIT_HI.
  - WAIT_LO + hi word: overwrite stored hi, set sync_err, stay in WAIT_LO.
  - in_valid = 0: no state change.
- Arithmetic:
  - Stage 1 (edge that samples the lo word): sum = zero-extended result + sign-extended bias, 20-bit signed, cannot overflow.
  - Stage 2: sum >>> min(shift, 19), arithmetic shift.
  - RELU = 1: negative → 0; >255 → 255.
  - RELU = 0: <-128 → 0x80; >127 → 0x7F.
- Latency:
  - Stage 2 output is written into the FIFO on the next edge.
  - out_valid rises 3 edges after the edge that sampled the lo word, if the FIFO was empty.
  - Sustained throughput is one result per 2 input words.
- Config:
  - A cfg_we write takes effect on the next edge.
  - A write in the same cycle as a lo word: that result uses the OLD value.
  - The value is captured at stage 1 for bias and at stage 2 for shift, registered alongside the data.
  - To be fully coherent, software writes config only while the pipeline is idle.
- FIFO:
  - Pop when out_valid && out_ready.
  - out_data holds the head and is stable while out_valid && !out_ready.
  - Simultaneous push and pop when full: both occur, no overflow.
  - Push when full with no pop: drop the new result, set ovf_err, keep the existing contents intact.
  - Wrap-around of the read and write pointers is exercised by DEPTH+1 sustained transfers.
- Sticky flags: err_clr clears sync_err and ovf_err. If a set event and err_clr occur in the same cycle, set wins.
- No backpressure reaches the input: upstream is free-running.

Test Plan:
1. Reset, RELU=1, bias=+20, shift=0; send hi=0x000, lo=0x0F0 (result 240) → sum 260 → out_data=0xFF, valid 3 edges after the lo word.
2. bias=-8, shift=2; result 1000 (hi=0x001, lo=0x1E8) → 992>>>2=248 → out_data=0xF8. Then bias=-300, result 100 → -200 → out_data=0x00.
3. RELU=0 build, bias=0, shift=10; result 0x3FFFF → 255 → 0x7F. Bias=-2048, shift=4, result 0 → -128 → 0x80.
4. Pairing errors:
   - lo word in WAIT_HI → discarded, sync_err=1, no output.
   - hi=0x005 then hi=0x000, lo=0x010 → single output from result 16.
   - err_clr → sync_err=0.
5. Overflow: out_ready=0, push 5 results 1..5 (bias 0, shift 0) → first 4 held, ovf_err=1. Drain with out_ready=1 → outputs 1,2,3,4 in order, then out_valid=0. Repeat with out_ready=1 throughout for 9 results → no ovf_err, correct order across pointer wrap.
6. Assert rst while in WAIT_LO with 2 FIFO entries → next edge: out_valid=0, flags clear. A following lo word is discarded with sync_err=1.
